// File: rtl/adt7310_spi_responder.sv
// SPI mode-3 slave emulating the ADT7310 register map (status, config, temperature, ID),
// with a cycle-timed conversion model feeding the temperature register.
//
// state    | meaning
// ST_IDLE  | CS_n high, or waiting for a CS_n fall
// ST_CMD   | shifting in the 8-bit command byte
// ST_READ  | shifting out the addressed register, repeating after the last bit
// ST_WRITE | shifting in one data byte; further bits ignored
module adt7310_spi_responder #(
    parameter int         SyncStages = 2,
    parameter int         ConvCycles = 240,
    parameter logic [7:0] DeviceID   = 8'hC3
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        SCK_i,
    input  logic        MOSI_i,
    input  logic        CS_n_i,
    output logic        MISO_o,
    output logic        MISO_En_o,
    input  logic [15:0] Temperature_i,
    output logic [7:0]  ConfigReg_o,
    output logic        ConvBusy_o
);

    localparam int                TimerW    = $clog2(ConvCycles);
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(ConvCycles - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_READ, ST_WRITE} state_t;

    state_t state, state_next;

    logic [SyncStages-1:0] sck_sync, mosi_sync, cs_sync;
    logic sck_prev, cs_prev;
    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall;

    logic [3:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  rx_byte;
    logic [2:0]  addr_q;
    logic [15:0] out_sh;
    logic [3:0]  out_cnt;
    logic        out_16;
    logic        miso_q;
    logic        decode, wr_commit, temp_decode, temp_read_active;

    logic [7:0]        config_q;
    logic [1:0]        mode;
    logic              busy;
    logic [TimerW-1:0] timer;
    logic              start_req;
    logic              conv_done;
    logic [15:0]       temp_reg, pend_val;
    logic              pend, rdy_n;
    logic [7:0]        status;

    function automatic logic [15:0] reg_value(input logic [2:0]  addr,
                                              input logic [7:0]  stat,
                                              input logic [7:0]  cfg,
                                              input logic [15:0] tmp);
        case (addr)
            3'd0:    reg_value = {stat, 8'h00};
            3'd1:    reg_value = {cfg, 8'h00};
            3'd2:    reg_value = tmp;
            3'd3:    reg_value = {DeviceID, 8'h00};
            default: reg_value = 16'h0000;
        endcase
    endfunction

    // CS chain resets to asserted so a transaction in flight at reset release
    // is not mistaken for a fresh CS_n fall.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            sck_sync  <= '1;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_prev  <= 1'b1;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SyncStages-2:0], SCK_i};
            mosi_sync <= {mosi_sync[SyncStages-2:0], MOSI_i};
            cs_sync   <= {cs_sync[SyncStages-2:0], CS_n_i};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SyncStages-1];
    assign mosi_s   = mosi_sync[SyncStages-1];
    assign cs_s     = cs_sync[SyncStages-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign rx_byte  = {shift_in, mosi_s};

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cs_fall) state_next = ST_CMD;
            ST_CMD: begin
                if (cs_s)        state_next = ST_IDLE;
                else if (decode) state_next = rx_byte[6] ? ST_READ : ST_WRITE;
            end
            default: if (cs_s) state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        decode    = 1'b0;
        wr_commit = 1'b0;
        MISO_En_o = 1'b0;
        MISO_o    = 1'b0;
        if (state == ST_CMD && !cs_s && sck_rise && bit_cnt == 4'd7)
            decode = 1'b1;
        if (state == ST_WRITE && !cs_s && sck_rise && bit_cnt == 4'd7 && addr_q == 3'd1)
            wr_commit = 1'b1;
        MISO_En_o = (state != ST_IDLE);
        MISO_o    = (state == ST_READ) && miso_q;
    end

    assign temp_decode      = decode && rx_byte[6] && (rx_byte[5:3] == 3'd2);
    assign temp_read_active = (state == ST_READ && addr_q == 3'd2) || temp_decode;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            bit_cnt  <= '0;
            shift_in <= '0;
            addr_q   <= '0;
            out_sh   <= '0;
            out_cnt  <= '0;
            out_16   <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && cs_fall)
                bit_cnt <= '0;
            else if (decode)
                bit_cnt <= '0;
            else if (sck_rise && !cs_s && (state == ST_CMD || state == ST_WRITE) && bit_cnt != 4'd8)
                bit_cnt <= bit_cnt + 4'd1;

            if (sck_rise && !cs_s && (state == ST_CMD || state == ST_WRITE))
                shift_in <= rx_byte[6:0];

            if (decode) begin
                addr_q  <= rx_byte[5:3];
                out_sh  <= reg_value(rx_byte[5:3], status, config_q, temp_reg);
                out_cnt <= '0;
                out_16  <= (rx_byte[5:3] == 3'd2);
                miso_q  <= 1'b0;
            end else if (state == ST_READ && sck_fall && !cs_s) begin
                miso_q <= out_sh[15];
                if (out_cnt == (out_16 ? 4'd15 : 4'd7)) begin
                    out_sh  <= reg_value(addr_q, status, config_q, temp_reg);
                    out_cnt <= '0;
                end else begin
                    out_sh  <= {out_sh[14:0], 1'b0};
                    out_cnt <= out_cnt + 4'd1;
                end
            end
        end
    end

    assign mode      = config_q[6:5];
    assign status    = {rdy_n, 7'b0};
    assign conv_done = busy && (timer == '0) && (mode != 2'b11);

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            config_q  <= 8'h00;
            busy      <= 1'b0;
            timer     <= '0;
            start_req <= 1'b1;
            temp_reg  <= 16'h0000;
            pend_val  <= 16'h0000;
            pend      <= 1'b0;
            rdy_n     <= 1'b1;
        end else begin
            start_req <= 1'b0;
            if (mode == 2'b11) begin
                busy <= 1'b0;
            end else if (conv_done) begin
                if (mode == 2'b01) busy <= 1'b0;
                timer <= TimerLoad;
            end else if (busy) begin
                timer <= timer - TimerW'(1);
            end

            if (start_req) begin
                busy  <= 1'b1;
                timer <= TimerLoad;
            end

            if (wr_commit) begin
                config_q <= rx_byte;
                case (rx_byte[6:5])
                    2'b00, 2'b01: begin
                        busy  <= 1'b1;
                        timer <= TimerLoad;
                    end
                    2'b10: if (!busy) begin
                        busy  <= 1'b1;
                        timer <= TimerLoad;
                    end
                    default: busy <= 1'b0;
                endcase
            end

            // A capture landing during a temperature read waits for CS_n to go high.
            if (pend && state == ST_IDLE) begin
                temp_reg <= pend_val;
                rdy_n    <= 1'b0;
                pend     <= 1'b0;
            end
            if (conv_done) begin
                if (temp_read_active) begin
                    pend     <= 1'b1;
                    pend_val <= Temperature_i;
                end else begin
                    temp_reg <= Temperature_i;
                    rdy_n    <= 1'b0;
                    pend     <= 1'b0;
                end
            end
            if (temp_decode) rdy_n <= 1'b1;
        end
    end

    assign ConfigReg_o = config_q;
    assign ConvBusy_o  = busy;

endmodule

// File: tb/tb_adt7310_spi_responder.sv
// Directed bench for adt7310_spi_responder: register reads/writes, continuous read,
// conversion modes, deferred capture during a temperature read, aborts and mid-transfer reset.
module tb_adt7310_spi_responder;

    localparam int Conv = 200;
    localparam int Half = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck, mosi, cs_n;
    logic        miso, miso_en;
    logic [15:0] temp_in;
    logic [7:0]  cfg;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adt7310_spi_responder #(
        .SyncStages(2),
        .ConvCycles(Conv),
        .DeviceID  (8'hC3)
    ) dut (
        .Clk_i        (clk),
        .Reset_i      (rst),
        .SCK_i        (sck),
        .MOSI_i       (mosi),
        .CS_n_i       (cs_n),
        .MISO_o       (miso),
        .MISO_En_o    (miso_en),
        .Temperature_i(temp_in),
        .ConfigReg_o  (cfg),
        .ConvBusy_o   (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [15:0] tx, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sck  = 1'b0;
            mosi = tx[n-1-i];
            repeat (Half) @(negedge clk);
            rx   = {rx[14:0], miso};
            sck  = 1'b1;
            repeat (Half) @(negedge clk);
        end
    endtask

    task automatic cs_on();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_off();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wr_cfg(input logic [7:0] v);
        logic [15:0] dummy;
        cs_on();
        spi_bits({8'h08, v}, 16, dummy);
        cs_off();
    endtask

    task automatic rd(input logic [7:0] cmd, input int n, output logic [15:0] data);
        logic [15:0] dummy;
        cs_on();
        spi_bits({8'h00, cmd}, 8, dummy);
        spi_bits(16'h0000, n, data);
        cs_off();
    endtask

    initial begin
        logic [15:0] rx;
        rst     = 1'b1;
        sck     = 1'b1;
        mosi    = 1'b0;
        cs_n    = 1'b1;
        temp_in = 16'h0C80;
        repeat (3) @(negedge clk);
        check("rst_miso", {15'h0, miso}, 16'h0000);
        check("rst_miso_en", {15'h0, miso_en}, 16'h0000);
        check("rst_cfg", {8'h0, cfg}, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);
        check("rst_temp", dut.temp_reg, 16'h0000);

        // conversion boundary: capture lands exactly Conv+1 cycles after release
        rst = 1'b0;
        repeat (Conv) @(negedge clk);
        check("t1_temp_before", dut.temp_reg, 16'h0000);
        check("t1_status_before", {8'h0, dut.rdy_n, 7'b0}, 16'h0080);
        @(negedge clk);
        check("t1_temp_after", dut.temp_reg, 16'h0C80);
        check("t1_status_after", {8'h0, dut.rdy_n, 7'b0}, 16'h0000);
        check("t1_busy_cont", {15'h0, busy}, 16'h0001);
        rd(8'h40, 8, rx);
        check("t1_rd_status", rx, 16'h0000);
        rd(8'h50, 16, rx);
        check("t1_rd_temp", rx, 16'h0C80);

        wr_cfg(8'h20);
        check("t2_cfg", {8'h0, cfg}, 16'h0020);
        check("t2_busy_on", {15'h0, busy}, 16'h0001);
        repeat (Conv + 20) @(negedge clk);
        check("t2_busy_off", {15'h0, busy}, 16'h0000);

        temp_in = 16'h1234;
        wr_cfg(8'h20);
        repeat (Conv + 20) @(negedge clk);
        rd(8'h50, 16, rx);
        check("t3_rd_temp", rx, 16'h1234);
        rd(8'h40, 8, rx);
        check("t3_rd_status", rx, 16'h0080);

        rd(8'h58, 16, rx);
        check("t4_id_first", {8'h0, rx[15:8]}, 16'h00C3);
        check("t4_id_repeat", {8'h0, rx[7:0]}, 16'h00C3);

        wr_cfg(8'h00);
        check("t5_cfg_cont", {8'h0, cfg}, 16'h0000);
        check("t5_busy_cont", {15'h0, busy}, 16'h0001);
        cs_on();
        spi_bits(16'h0008, 8, rx);
        spi_bits(16'h0006, 4, rx);
        cs_off();
        check("t5_abort_cfg", {8'h0, cfg}, 16'h0000);
        check("t5_abort_en", {15'h0, miso_en}, 16'h0000);
        wr_cfg(8'h60);
        check("t5_cfg_sd", {8'h0, cfg}, 16'h0060);
        check("t5_busy_sd", {15'h0, busy}, 16'h0000);

        // one-shot whose completion falls inside the following temperature read
        temp_in = 16'h5678;
        wr_cfg(8'h20);
        rd(8'h50, 16, rx);
        check("t6_rd_held", rx, 16'h1234);
        rd(8'h40, 8, rx);
        check("t6_status_applied", rx, 16'h0000);
        rd(8'h50, 16, rx);
        check("t6_rd_new", rx, 16'h5678);

        cs_on();
        spi_bits(16'h000B, 5, rx);
        rst = 1'b1;
        @(negedge clk);
        check("t7_miso", {15'h0, miso}, 16'h0000);
        check("t7_miso_en", {15'h0, miso_en}, 16'h0000);
        check("t7_cfg", {8'h0, cfg}, 16'h0000);
        check("t7_busy", {15'h0, busy}, 16'h0000);
        check("t7_temp", dut.temp_reg, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t7_en_wait_fall", {15'h0, miso_en}, 16'h0000);
        check("t7_busy_restart", {15'h0, busy}, 16'h0001);
        cs_off();
        rd(8'h58, 8, rx);
        check("t7_rd_id", rx, 16'h00C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
